mc_core: RTL
============

Name: mc_core

Overview:
- Multicycle successor to the single-cycle MIPS datapath: same ISA subset, but one shared memory port and internal state registers (IR, MDR, A, B, ALUOut), driven by an integrated control FSM.
- Each instruction takes 3-5 states plus memory wait cycles.
- Sits between the top level and a unified instruction/data memory that uses a req/ready handshake.
- Adds variable-latency memory, illegal-opcode trapping and a retire strobe.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_ON_ILLEGAL, 1: 1 = enter HALT on an unsupported opcode/funct; 0 = treat it as NOP and continue.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, valid while mem_req is high.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load/fetch data, valid when mem_ready is high.
- mem_ready  in  1  access complete this cycle.
- pc  out  32  current PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky flag: an unsupported instruction was decoded.
- halted  out  1  high while in HALT.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; state=FETCH.
  - mem_req=0, retire=0, illegal=0, halted=0.
  - IR/MDR/A/B/ALUOut=0.
  - Register file contents are not reset; r0 always reads 0.
- Supported ISA: R-type add, sub, and, or, slt; lw, sw, beq, addi, j.
- ALU ops:
  - 32-bit two's complement; overflow ignored.
  - slt is a signed compare.
  - zero = (result==0).
- Immediates: sign-extended; branch offset = signimm<<2.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until a cycle with mem_ready=1.
  - Completion is on that edge; mem_ready may be high in the same cycle req rises (zero-wait).
  - mem_ready while mem_req=0 is ignored.
  - Next request is earliest the following cycle; mem_req is deasserted for at least one cycle between accesses.
- States and transitions:
  - FETCH: req read at pc. On ready: IR<=rdata, pc<=pc+4, go to DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=pc+(signimm<<2). Dispatch:
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - other -> ILLEGAL
  - MEMADR: ALUOut<=A+signimm. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: req read at ALUOut. On ready: MDR<=rdata, go to MEMWB.
  - MEMWB: rf[rt]<=MDR; retire; go to FETCH.
  - MEMWR: req write, addr=ALUOut, wdata=B. On ready: retire, go to FETCH.
  - EXECUTE: ALUOut<=A op B (per funct); go to ALUWB.
  - ALUWB: rf[rd]<=ALUOut; retire; go to FETCH.
  - BRANCH: if A==B then pc<=ALUOut. Retire; go to FETCH.
  - ADDIEX: ALUOut<=A+signimm; go to ADDIWB.
  - ADDIWB: rf[rt]<=ALUOut; retire; go to FETCH.
  - JUMP: pc<={pc[31:28],IR[25:0],2'b00}; retire; go to FETCH.
  - ILLEGAL: illegal<=1. If HALT_ON_ILLEGAL, go to HALT; else retire, go to FETCH.
  - HALT: halted=1, mem_req=0. Exits only on reset.
- Boundary conditions:
  - Writes to r0 are discarded.
  - beq uses pc+4 as the base, since pc was already incremented in FETCH.
  - pc wraps modulo 2^32.
  - Unaligned addresses: low two bits are driven as computed; alignment is not checked.
  - Reset asserted mid-access drops mem_req immediately; the partial access is discarded.
- retire is high exactly one cycle per completed instruction.

Optional Feature:
- MC_CORE_PERF_CNT_EN. When defined, adds:
  - output cycle_cnt[31:0]: increments every cycle not in HALT.
  - output instret_cnt[31:0]: increments on retire.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, the ports are absent and no counter logic is built.

Decomposition:
- Package mc_pkg holds:
  - opcode constants (RTYPE=6'h00, LW=6'h23, SW=6'h2B, BEQ=6'h04, ADDI=6'h08, J=6'h02);
  - funct constants (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, SLT=6'h2A);
  - 3-bit ALU control codes;
  - state enum.
- One natural sub-module: mc_ctrl_fsm, holding the state register, next-state logic and per-state control outputs. Datapath registers stay in mc_core.
- Existing register-file, ALU and sign-extend blocks are reused.

Test Plan:
- Zero-wait memory, addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> rf[3]=12; three retire pulses, 4 cycles each.
- sw r3,8(r0) then lw r4,8(r0), memory inserting 3 wait cycles per access -> mem_addr=8, wdata=12 held stable through waits; rf[4]=12.
- beq r1,r1,-1 at pc=0x10 -> pc returns to 0x10; beq r1,r2 with unequal values -> pc=0x14.
- j 0x40 at pc=0x1000_0000 -> pc=0x1000_0100; add r0,r1,r2 -> r0 still reads 0.
- Opcode 6'h3F with HALT_ON_ILLEGAL=1 -> illegal=1, halted=1, mem_req stays 0; with HALT_ON_ILLEGAL=0 -> retire pulses, fetch continues at pc+4.
- Assert reset during a MEMRD wait -> mem_req=0 in the same cycle; after release, first fetch is at RESET_PC. With MC_CORE_PERF_CNT_EN, check that instret_cnt equals the number of retire pulses.

Source files
------------

// File: rtl/mc_core_pkg.sv
// mc_pkg: opcode/funct encodings, ALU control codes, FSM states and ALU helpers
// shared by mc_core and mc_ctrl_fsm.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_ILLEGAL,
    S_HALT
  } state_e;

  function automatic logic funct_ok(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic alu_ctrl_e funct_to_alu(input logic [5:0] funct);
    alu_ctrl_e c;
    case (funct)
      FN_SUB:  c = ALU_SUB;
      FN_AND:  c = ALU_AND;
      FN_OR:   c = ALU_OR;
      FN_SLT:  c = ALU_SLT;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input alu_ctrl_e ctrl);
    logic [31:0] r;
    case (ctrl)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_core_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM with registered memory/status outputs.
import mc_pkg::*;

module mc_ctrl_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output state_e     state,
  output logic       mem_done,
  output logic       mem_req,
  output logic       mem_we,
  output logic       retire,
  output logic       illegal,
  output logic       halted
);

  state_e state_q, state_d;
  logic   mem_req_q, mem_req_d;
  logic   mem_we_q, mem_we_d;
  logic   retire_q, retire_d;
  logic   illegal_q, illegal_d;
  logic   halted_q, halted_d;

  // Outputs are derived from the next state so they line up with state_q;
  // the !mem_done term forces an idle cycle between back-to-back accesses.
  always_comb begin
    mem_done  = mem_req_q & mem_ready;
    state_d   = state_q;
    retire_d  = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:   if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok(funct) ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_done) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_done) begin
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_d = 1'b1;
        if (HALT_ON_ILLEGAL) begin
          state_d = S_HALT;
        end else begin
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
    mem_req_d = ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR)) && !mem_done;
    mem_we_d  = mem_req_d && (state_d == S_MEMWR);
    halted_d  = (state_d == S_HALT);
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  assign state   = state_q;
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign retire  = retire_q;
  assign illegal = illegal_q;
  assign halted  = halted_q;

endmodule

// File: rtl/mc_core.sv
// mc_core: multicycle MIPS-subset core with a single req/ready memory port.
// Optional MC_CORE_PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
import mc_pkg::*;

module mc_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal,
  output logic        halted
`ifdef MC_CORE_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_e      state;
  logic        mem_done;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] signimm, rs_val, rt_val;

  assign opcode  = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rs_val  = (rs == '0) ? '0 : rf_q[rs];
  assign rt_val  = (rt == '0) ? '0 : rf_q[rt];

  mc_ctrl_fsm #(
    .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .mem_ready (mem_ready),
    .state     (state),
    .mem_done  (mem_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .retire    (retire),
    .illegal   (illegal),
    .halted    (halted)
  );

  // Per-state datapath register updates and register-file write selection.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = aluout_q;
    case (state)
      S_FETCH: begin
        if (mem_done) begin
          ir_d = mem_rdata;
          pc_d = pc_q + 32'd4;
        end
      end
      S_DECODE: begin
        a_d      = rs_val;
        b_d      = rt_val;
        aluout_d = pc_q + {signimm[29:0], 2'b00};
      end
      S_MEMADR, S_ADDIEX: aluout_d = a_q + signimm;
      S_MEMRD:   if (mem_done) mdr_d = mem_rdata;
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
      end
      S_EXECUTE: aluout_d = alu(a_q, b_q, funct_to_alu(funct));
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
      end
      S_ADDIWB:  rf_we = 1'b1;
      S_BRANCH:  if (alu(a_q, b_q, ALU_SUB) == '0) pc_d = aluout_q;
      S_JUMP:    pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: ;
    endcase
    mem_addr  = (state == S_FETCH) ? pc_q : aluout_q;
    mem_wdata = b_q;
  end

  // Architectural and internal datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  // Register file: not reset, r0 never written.
  always_ff @(posedge clk) begin
    if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
  end

  assign pc = pc_q;

`ifdef MC_CORE_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  // Free-running cycle counter (frozen in HALT) and retired-instruction counter.
  always_comb begin
    cycle_cnt_d   = (state != S_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    instret_cnt_d = retire ? instret_cnt_q + 32'd1 : instret_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
